l1_tag_lookup: RTL and testbench
================================

// Module: l1_tag_lookup
// PURPOSE
//  Tag/valid/dirty store and hit/miss detector for a 4-way set-associative L1.
//  Sits directly upstream of the per-set LRU_4way tracker.
//  On a miss, picks the victim from the LRU's evict_way and allocates the new tag.
//  Drives the LRU's access_way/access_valid pulse for every completed lookup.
// PARAMETERS
//  ADDR_W   32  request address width
//  OFFSET_W 6   line offset bits (64 B lines)
//  INDEX_W  4   set index bits (2**INDEX_W sets)
//  TAG_W    ADDR_W-INDEX_W-OFFSET_W (localparam, derived)
// PORTS
//  clk              in  1        clock, rising edge
//  rst_n            in  1        asynchronous, active-low reset
//  req_valid        in  1        request present
//  req_ready        out 1        block can accept a request
//  req_addr         in  ADDR_W   byte address
//  req_write        in  1        1=write (sets dirty), 0=read
//  rsp_valid        out 1        one-cycle response strobe
//  rsp_hit          out 1        1=hit, 0=miss (line now allocated)
//  rsp_way          out 2        way hit or allocated
//  rsp_evict_valid  out 1        miss replaced a valid line
//  rsp_evict_dirty  out 1        replaced line was dirty (writeback needed)
//  rsp_evict_tag    out TAG_W    tag of replaced line
//  lru_set          out INDEX_W  set index presented to LRU mux
//  lru_evict_way    in  2        LRU victim for lru_set (combinational from LRU)
//  lru_access_way   out 2        to LRU access_way
//  lru_access_valid out 1        to LRU access_valid
//  hit_cnt          out 32       saturating hit counter
//  miss_cnt         out 32       saturating miss counter
// BEHAVIOUR
//  Reset (rst_n=0, async): every valid/dirty bit cleared, FSM=IDLE, all outputs 0
//    except req_ready=1 after the first edge with rst_n=1; counters=0.
//  Address split: tag=addr[ADDR_W-1:INDEX_W+OFFSET_W], index=addr[INDEX_W+OFFSET_W-1:OFFSET_W].
//  FSM IDLE -> LOOKUP -> RESPOND -> IDLE; req_ready=1 only in IDLE.
//   IDLE: req_valid&req_ready latches addr/write, go LOOKUP.
//   LOOKUP: lru_set=latched index; compare tag vs 4 ways (valid only);
//    victim = lowest-numbered invalid way, else lru_evict_way (sampled this cycle).
//   RESPOND: rsp_* and lru_access_valid high exactly one cycle;
//    lru_access_way=rsp_way; lru_set held stable LOOKUP..RESPOND.
//    Hit: rsp_evict_*=0; write hit sets dirty.
//    Miss: write tag into victim, valid=1, dirty=req_write;
//     rsp_evict_valid/dirty/tag report victim state before overwrite (0 if invalid).
//  Latency: rsp_valid 2 cycles after accept; throughput 1 request per 3 cycles.
//  No rsp backpressure: consumer must take rsp_valid in its cycle.
//  Tag hit in >1 way cannot occur by construction; lowest way wins if it does.
//  hit_cnt/miss_cnt increment in RESPOND; hold at 32'hFFFF_FFFF (no wrap).
//  Reset mid-operation: in-flight request dropped, no rsp_valid, no LRU pulse.
//  rsp_* outputs are 0 in every cycle where rsp_valid=0.
// TESTING (OFFSET_W=6, INDEX_W=4; set 0 tags: 0x400->1, 0x800->2, 0xC00->3)
//  1 reset, read 0x400 -> 2 cycles later rsp_hit=0, rsp_way=0, evict_valid=0,
//    lru_access_valid pulse with way 0, miss_cnt=1.
//  2 read 0x400 again -> rsp_hit=1, rsp_way=0, hit_cnt=1, dirty unchanged.
//  3 fill ways with 0x400,0x800,0xC00,0x1000; read 0x1400 with lru_evict_way=2
//    -> miss, rsp_way=2, evict_valid=1, evict_dirty=0, evict_tag=0x3.
//  4 write 0x800 (hit, way 1), then miss 0x1800 with lru_evict_way=1
//    -> evict_valid=1, evict_dirty=1, evict_tag=0x2.
//  5 req_valid held high -> req_ready 1,0,0 repeating; one rsp per 3 cycles.
//  6 drop rst_n during LOOKUP -> no rsp_valid/LRU pulse, outputs 0; re-read same
//    address -> miss. Force hit_cnt to 0xFFFF_FFFF, hit -> stays 0xFFFF_FFFF.

Source files
------------

// File: rtl/l1_tag_lookup.sv
// Tag/valid/dirty store with hit/miss detection and victim allocation for a 4-way set-associative L1.
// Latency: response 2 cycles after accept, one request per 3 cycles; no response backpressure.
module l1_tag_lookup #(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 6,
    parameter int INDEX_W  = 4,
    localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic               req_write,
    output logic               rsp_valid,
    output logic               rsp_hit,
    output logic [1:0]         rsp_way,
    output logic               rsp_evict_valid,
    output logic               rsp_evict_dirty,
    output logic [TAG_W-1:0]   rsp_evict_tag,
    output logic [INDEX_W-1:0] lru_set,
    input  logic [1:0]         lru_evict_way,
    output logic [1:0]         lru_access_way,
    output logic               lru_access_valid,
    output logic [31:0]        hit_cnt,
    output logic [31:0]        miss_cnt
);
    localparam int SETS = 1 << INDEX_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOOKUP  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t           state;
    logic [TAG_W-1:0] tag_q   [SETS][4];
    logic [3:0]       valid_q [SETS];
    logic [3:0]       dirty_q [SETS];
    logic [TAG_W-1:0] req_tag;
    logic             req_wr;

    logic             hit;
    logic [1:0]       hit_way;
    logic             inv_found;
    logic [1:0]       inv_way;
    logic [1:0]       victim;
    logic [1:0]       sel_way;
    logic [31:0]      hit_nxt;
    logic [31:0]      miss_nxt;

    // Offset bits never take part in tag matching.
    logic unused_offset;
    assign unused_offset = ^req_addr[OFFSET_W-1:0];

    // Descending scans so the lowest-numbered way wins on both searches.
    always_comb begin
        hit       = 1'b0;
        hit_way   = 2'd0;
        inv_found = 1'b0;
        inv_way   = 2'd0;
        for (int w = 3; w >= 0; w--) begin
            if (valid_q[lru_set][w] && (tag_q[lru_set][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = 2'(w);
            end
            if (!valid_q[lru_set][w]) begin
                inv_found = 1'b1;
                inv_way   = 2'(w);
            end
        end
        victim  = inv_found ? inv_way : lru_evict_way;
        sel_way = hit ? hit_way : victim;
    end

    always_comb begin
        hit_nxt  = hit_cnt;
        miss_nxt = miss_cnt;
        if (state == LOOKUP) begin
            if (hit) begin
                if (hit_cnt != 32'hFFFF_FFFF) hit_nxt = hit_cnt + 32'd1;
            end else begin
                if (miss_cnt != 32'hFFFF_FFFF) miss_nxt = miss_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
        end else begin
            hit_cnt  <= hit_nxt;
            miss_cnt <= miss_nxt;
        end
    end

    // Tag storage needs no reset: a way is only ever read when its valid bit is set.
    always_ff @(posedge clk) begin
        if (state == LOOKUP && !hit) begin
            tag_q[lru_set][victim] <= req_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            req_ready        <= 1'b0;
            req_tag          <= '0;
            req_wr           <= 1'b0;
            lru_set          <= '0;
            rsp_valid        <= 1'b0;
            rsp_hit          <= 1'b0;
            rsp_way          <= 2'd0;
            rsp_evict_valid  <= 1'b0;
            rsp_evict_dirty  <= 1'b0;
            rsp_evict_tag    <= '0;
            lru_access_valid <= 1'b0;
            lru_access_way   <= 2'd0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= 4'd0;
                dirty_q[s] <= 4'd0;
            end
        end else begin
            rsp_valid        <= 1'b0;
            rsp_hit          <= 1'b0;
            rsp_way          <= 2'd0;
            rsp_evict_valid  <= 1'b0;
            rsp_evict_dirty  <= 1'b0;
            rsp_evict_tag    <= '0;
            lru_access_valid <= 1'b0;
            lru_access_way   <= 2'd0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_tag   <= req_addr[ADDR_W-1:INDEX_W+OFFSET_W];
                        lru_set   <= req_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
                        req_wr    <= req_write;
                        req_ready <= 1'b0;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    rsp_valid        <= 1'b1;
                    rsp_hit          <= hit;
                    rsp_way          <= sel_way;
                    lru_access_valid <= 1'b1;
                    lru_access_way   <= sel_way;
                    if (hit) begin
                        if (req_wr) dirty_q[lru_set][hit_way] <= 1'b1;
                    end else begin
                        // Report the victim as it was before being overwritten.
                        rsp_evict_valid <= valid_q[lru_set][victim];
                        rsp_evict_dirty <= valid_q[lru_set][victim] & dirty_q[lru_set][victim];
                        rsp_evict_tag   <= valid_q[lru_set][victim] ? tag_q[lru_set][victim] : '0;
                        valid_q[lru_set][victim] <= 1'b1;
                        dirty_q[lru_set][victim] <= req_wr;
                    end
                    state <= RESPOND;
                end
                RESPOND: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    req_ready <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_l1_tag_lookup.sv
// Scoreboard bench for l1_tag_lookup: a behavioural cache model predicts each response at accept time.
module tb_l1_tag_lookup;
    localparam int TAG_W = 22;
    localparam int SETS  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [31:0]       req_addr = 32'd0;
    logic              req_write = 1'b0;
    logic              rsp_valid;
    logic              rsp_hit;
    logic [1:0]        rsp_way;
    logic              rsp_evict_valid;
    logic              rsp_evict_dirty;
    logic [TAG_W-1:0]  rsp_evict_tag;
    logic [3:0]        lru_set;
    logic [1:0]        lru_evict_way = 2'd0;
    logic [1:0]        lru_access_way;
    logic              lru_access_valid;
    logic [31:0]       hit_cnt;
    logic [31:0]       miss_cnt;

    l1_tag_lookup dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_write(req_write),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
        .rsp_evict_valid(rsp_evict_valid), .rsp_evict_dirty(rsp_evict_dirty), .rsp_evict_tag(rsp_evict_tag),
        .lru_set(lru_set), .lru_evict_way(lru_evict_way),
        .lru_access_way(lru_access_way), .lru_access_valid(lru_access_valid),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic             hit;
        logic [1:0]       way;
        logic             ev_vld;
        logic             ev_dirty;
        logic [TAG_W-1:0] ev_tag;
        logic [3:0]       set;
        logic [31:0]      hc;
        logic [31:0]      mc;
        int               cycle;
    } exp_t;

    exp_t sb[$];
    exp_t me;

    logic [TAG_W-1:0] m_tag   [SETS][4];
    logic             m_vld   [SETS][4];
    logic             m_dirty [SETS][4];
    logic [31:0]      m_hits   = 32'd0;
    logic [31:0]      m_misses = 32'd0;

    logic             last_hit;
    logic [1:0]       last_way;
    logic             last_ev_vld;
    logic             last_ev_dirty;
    logic [TAG_W-1:0] last_ev_tag;

    task automatic model_clear();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < 4; w++) begin
                m_vld[s][w]   = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_tag[s][w]   = '0;
            end
        m_hits   = 32'd0;
        m_misses = 32'd0;
    endtask

    task automatic model_push(input logic [31:0] a, input logic wr, input logic [1:0] ev, input int c);
        exp_t e;
        int s;
        int way;
        logic [TAG_W-1:0] t;
        s = int'(a[9:6]);
        t = a[31:10];
        way = -1;
        for (int w = 3; w >= 0; w--)
            if (m_vld[s][w] && m_tag[s][w] == t) way = w;
        e.set   = a[9:6];
        e.cycle = c;
        if (way >= 0) begin
            e.hit = 1'b1; e.way = 2'(way);
            e.ev_vld = 1'b0; e.ev_dirty = 1'b0; e.ev_tag = '0;
            if (wr) m_dirty[s][way] = 1'b1;
            if (m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 32'd1;
        end else begin
            for (int w = 3; w >= 0; w--)
                if (!m_vld[s][w]) way = w;
            if (way < 0) way = int'(ev);
            e.hit      = 1'b0;
            e.way      = 2'(way);
            e.ev_vld   = m_vld[s][way];
            e.ev_dirty = m_vld[s][way] & m_dirty[s][way];
            e.ev_tag   = m_vld[s][way] ? m_tag[s][way] : '0;
            m_vld[s][way]   = 1'b1;
            m_dirty[s][way] = wr;
            m_tag[s][way]   = t;
            if (m_misses != 32'hFFFF_FFFF) m_misses = m_misses + 32'd1;
        end
        e.hc = m_hits;
        e.mc = m_misses;
        sb.push_back(e);
    endtask

    // Response monitor: every response must match the oldest prediction, and idle cycles must be quiet.
    always @(posedge clk) begin
        #1;
        if (rsp_valid) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rsp at cycle %0d: rsp_valid=1 with no outstanding request", cyc);
            end else begin
                me = sb.pop_front();
                last_hit = rsp_hit; last_way = rsp_way;
                last_ev_vld = rsp_evict_valid; last_ev_dirty = rsp_evict_dirty; last_ev_tag = rsp_evict_tag;
                if (cyc !== me.cycle) begin
                    n_fail++; $display("FAIL rsp_latency got cycle %0d want %0d", cyc, me.cycle);
                end
                n_checks++;
                if ({rsp_hit, rsp_way} !== {me.hit, me.way}) begin
                    n_fail++; $display("FAIL rsp_hit_way got hit=%0b way=%0d want hit=%0b way=%0d", rsp_hit, rsp_way, me.hit, me.way);
                end
                n_checks++;
                if ({rsp_evict_valid, rsp_evict_dirty, rsp_evict_tag} !== {me.ev_vld, me.ev_dirty, me.ev_tag}) begin
                    n_fail++; $display("FAIL rsp_evict got v=%0b d=%0b tag=%0h want v=%0b d=%0b tag=%0h",
                        rsp_evict_valid, rsp_evict_dirty, rsp_evict_tag, me.ev_vld, me.ev_dirty, me.ev_tag);
                end
                n_checks++;
                if ({lru_access_valid, lru_access_way, lru_set} !== {1'b1, me.way, me.set}) begin
                    n_fail++; $display("FAIL lru_pulse got v=%0b way=%0d set=%0d want v=1 way=%0d set=%0d",
                        lru_access_valid, lru_access_way, lru_set, me.way, me.set);
                end
                n_checks++;
                if ({hit_cnt, miss_cnt} !== {me.hc, me.mc}) begin
                    n_fail++; $display("FAIL counters got hit=%0h miss=%0h want hit=%0h miss=%0h", hit_cnt, miss_cnt, me.hc, me.mc);
                end
            end
        end else begin
            n_checks++;
            if ({rsp_hit, rsp_way, rsp_evict_valid, rsp_evict_dirty, rsp_evict_tag, lru_access_valid} !== '0) begin
                n_fail++; $display("FAIL idle_outputs_zero at cycle %0d: hit=%0b way=%0d ev=%0b/%0b/%0h lru_v=%0b want all 0",
                    cyc, rsp_hit, rsp_way, rsp_evict_valid, rsp_evict_dirty, rsp_evict_tag, lru_access_valid);
            end
        end
    end

    task automatic do_req(input logic [31:0] a, input logic wr, input logic [1:0] ev);
        int n = 0;
        @(negedge clk);
        req_addr = a; req_write = wr; lru_evict_way = ev; req_valid = 1'b1;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_checks++; n_fail++;
            $display("FAIL req_ready_timeout got req_ready=0 want 1 within 20 cycles");
            req_valid = 1'b0;
            return;
        end
        model_push(a, wr, ev, cyc + 2);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL rsp_timeout got %0d outstanding responses want 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        model_clear();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, lru_access_valid, hit_cnt, miss_cnt} !== '0) begin
            n_fail++; $display("FAIL reset_outputs got ready=%0b rsp_v=%0b lru_v=%0b hit=%0h miss=%0h want all 0",
                req_ready, rsp_valid, lru_access_valid, hit_cnt, miss_cnt);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++; $display("FAIL ready_before_edge got %0b want 0", req_ready);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL ready_after_edge got %0b want 1", req_ready);
        end
    endtask

    task automatic test_first_miss();
        do_req(32'h400, 1'b0, 2'd0);
        drain();
        n_checks++;
        if ({last_hit, last_way, last_ev_vld, miss_cnt} !== {1'b0, 2'd0, 1'b0, 32'd1}) begin
            n_fail++; $display("FAIL first_miss got hit=%0b way=%0d ev=%0b miss=%0d want 0/0/0/1", last_hit, last_way, last_ev_vld, miss_cnt);
        end
    endtask

    task automatic test_read_hit();
        do_req(32'h400, 1'b0, 2'd3);
        drain();
        n_checks++;
        if ({last_hit, last_way, hit_cnt} !== {1'b1, 2'd0, 32'd1}) begin
            n_fail++; $display("FAIL read_hit got hit=%0b way=%0d hit_cnt=%0d want 1/0/1", last_hit, last_way, hit_cnt);
        end
    endtask

    task automatic test_evict_clean();
        do_req(32'h800, 1'b0, 2'd0);
        do_req(32'hC00, 1'b0, 2'd0);
        do_req(32'h1000, 1'b0, 2'd0);
        do_req(32'h1400, 1'b0, 2'd2);
        drain();
        n_checks++;
        if ({last_hit, last_way, last_ev_vld, last_ev_dirty, last_ev_tag} !== {1'b0, 2'd2, 1'b1, 1'b0, 22'h3}) begin
            n_fail++; $display("FAIL evict_clean got hit=%0b way=%0d ev=%0b/%0b/%0h want 0/2/1/0/3",
                last_hit, last_way, last_ev_vld, last_ev_dirty, last_ev_tag);
        end
    endtask

    task automatic test_evict_dirty();
        do_req(32'h800, 1'b1, 2'd0);
        drain();
        n_checks++;
        if ({last_hit, last_way} !== {1'b1, 2'd1}) begin
            n_fail++; $display("FAIL write_hit got hit=%0b way=%0d want 1/1", last_hit, last_way);
        end
        do_req(32'h1800, 1'b0, 2'd1);
        drain();
        n_checks++;
        if ({last_hit, last_way, last_ev_vld, last_ev_dirty, last_ev_tag} !== {1'b0, 2'd1, 1'b1, 1'b1, 22'h2}) begin
            n_fail++; $display("FAIL evict_dirty got hit=%0b way=%0d ev=%0b/%0b/%0h want 0/1/1/1/2",
                last_hit, last_way, last_ev_vld, last_ev_dirty, last_ev_tag);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_write = 1'b0; lru_evict_way = 2'd0;
            req_addr = 32'h40 * 32'(i / 3 + 1);
            n_checks++;
            if (req_ready !== ((i % 3) == 0)) begin
                n_fail++; $display("FAIL ready_pattern step %0d got %0b want %0b", i, req_ready, (i % 3) == 0);
            end
            if (req_ready) model_push(req_addr, 1'b0, 2'd0, cyc + 2);
        end
        @(negedge clk);
        req_valid = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_addr = 32'h400; req_write = 1'b0; req_valid = 1'b1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_ready got %0b want 1", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, lru_access_valid, hit_cnt, miss_cnt} !== '0) begin
            n_fail++; $display("FAIL mid_reset_outputs got ready=%0b rsp_v=%0b lru_v=%0b hit=%0h miss=%0h want all 0",
                req_ready, rsp_valid, lru_access_valid, hit_cnt, miss_cnt);
        end
        model_clear();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_ready_after got %0b want 1", req_ready);
        end
        do_req(32'h400, 1'b0, 2'd0);
        drain();
        n_checks++;
        if ({last_hit, last_way} !== {1'b0, 2'd0}) begin
            n_fail++; $display("FAIL reread_after_reset got hit=%0b way=%0d want 0/0", last_hit, last_way);
        end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        force dut.hit_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.hit_cnt;
        m_hits = 32'hFFFF_FFFF;
        do_req(32'h400, 1'b0, 2'd0);
        drain();
        n_checks++;
        if ({last_hit, hit_cnt} !== {1'b1, 32'hFFFF_FFFF}) begin
            n_fail++; $display("FAIL hit_saturation got hit=%0b hit_cnt=%0h want 1/ffffffff", last_hit, hit_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_first_miss();
        test_read_hit();
        test_evict_clean();
        test_evict_dirty();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got simulation still running want finished");
        $fatal(1, "timeout");
    end
endmodule
